// File: rtl/stack_seq_pkg.sv
// Shared types and defaults for the return-address stack sequencer.
// Holds the FSM state encoding, the saved-flags layout and the default geometry/vectors.
package stack_seq_pkg;
  localparam int              SEQ_PC_W     = 12;
  localparam int              SEQ_DEPTH    = 8;
  localparam logic [11:0]     SEQ_RESET_PC = 12'h000;
  localparam logic [11:0]     SEQ_INT_VEC  = 12'h001;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    RET_LD  = 2'd1,
    RETI_LD = 2'd2,
    TRAP    = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic c;
    logic z;
  } flags_t;
endpackage

// File: rtl/stack_depth_cnt.sv
// Stack occupancy counter 0..DEPTH with full/empty flags; 1-cycle update, holds when cen=0.
// WRAP=1 wraps modulo DEPTH+1 to track a wrapping stack pointer, WRAP=0 saturates.
module stack_depth_cnt #(
  parameter int DEPTH = 8,
  parameter int W     = $clog2(DEPTH + 1),
  parameter bit WRAP  = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] depth,
  output logic         full,
  output logic         empty
);
  localparam logic [W-1:0] MAX = W'(DEPTH);

  assign full  = (depth == MAX);
  assign empty = (depth == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (cen) begin
      if (inc && !dec) begin
        depth <= full ? (WRAP ? '0 : depth) : depth + 1'b1;
      end else if (dec && !inc) begin
        depth <= empty ? (WRAP ? MAX : depth) : depth - 1'b1;
      end
    end
  end
endmodule

// File: rtl/stack_seq_ctrl.sv
// Call/ret/interrupt sequencer for the return-address stack; call/int 1 cycle, ret/reti 2 cycles.
// busy_o holds fetch during the pop-result cycle (and in TRAP); STACK_GUARD_EN enables overflow trap.
module stack_seq_ctrl
  import stack_seq_pkg::*;
#(
  parameter int              PC_W     = SEQ_PC_W,
  parameter int              DEPTH    = SEQ_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = SEQ_RESET_PC,
  parameter logic [PC_W-1:0] INT_VEC  = SEQ_INT_VEC,
  parameter int              DW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cen,
  input  logic [PC_W-1:0] next_pc_i,
  input  logic            call_i,
  input  logic [PC_W-1:0] call_tgt_i,
  input  logic            ret_i,
  input  logic            reti_i,
  input  logic            int_req_i,
  input  logic [1:0]      flags_i,
  input  logic [PC_W-1:0] stk_top_i,
  output logic            stk_push_o,
  output logic            stk_pop_o,
  output logic [PC_W-1:0] stk_pc_o,
  output logic [PC_W-1:0] pc_o,
  output logic            busy_o,
  output logic            int_ack_o,
  output logic            ie_o,
  output logic            flags_ld_o,
  output logic [1:0]      flags_o,
  output logic [DW-1:0]   depth_o,
  output logic            err_o
);
  seq_state_e      state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ie_q, ie_d;
  flags_t          flags_q, flags_d;
  logic            err_q, err_d;
  logic            push, pop, fault;
  logic            full, empty;
  logic            push_fault, pop_fault;

`ifdef STACK_GUARD_EN
  localparam bit WRAP = 1'b0;
  assign push_fault = full;
  assign pop_fault  = empty;
`else
  localparam bit WRAP = 1'b1;
  logic unused_flags;
  assign unused_flags = full ^ empty;
  assign push_fault   = 1'b0;
  assign pop_fault    = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ie_d       = ie_q;
    flags_d    = flags_q;
    err_d      = err_q;
    push       = 1'b0;
    pop        = 1'b0;
    fault      = 1'b0;
    busy_o     = 1'b0;
    int_ack_o  = 1'b0;
    flags_ld_o = 1'b0;
    case (state_q)
      RUN: begin
        if (call_i) begin
          if (push_fault) fault = 1'b1;
          else begin
            push = 1'b1;
            pc_d = call_tgt_i;
          end
        end else if (ret_i || reti_i) begin
          if (pop_fault) fault = 1'b1;
          else begin
            pop     = 1'b1;
            state_d = ret_i ? RET_LD : RETI_LD;
          end
        end else if (int_req_i && ie_q) begin
          if (push_fault) fault = 1'b1;
          else begin
            push      = 1'b1;
            pc_d      = INT_VEC;
            flags_d   = flags_t'(flags_i);
            ie_d      = 1'b0;
            int_ack_o = 1'b1;
          end
        end else begin
          pc_d = next_pc_i;
        end
      end
      RET_LD: begin
        busy_o  = 1'b1;
        pc_d    = stk_top_i;
        state_d = RUN;
      end
      RETI_LD: begin
        busy_o     = 1'b1;
        pc_d       = stk_top_i;
        state_d    = RUN;
        ie_d       = 1'b1;
        flags_ld_o = 1'b1;
      end
      default: busy_o = 1'b1;
    endcase
    // A guarded fault parks the sequencer on the vector until reset.
    if (fault) begin
      state_d = TRAP;
      pc_d    = INT_VEC;
      err_d   = 1'b1;
    end
    if (!cen || rst) begin
      push       = 1'b0;
      pop        = 1'b0;
      int_ack_o  = 1'b0;
      flags_ld_o = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      ie_q    <= 1'b1;
      flags_q <= '0;
      err_q   <= 1'b0;
    end else if (cen) begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ie_q    <= ie_d;
      flags_q <= flags_d;
      err_q   <= err_d;
    end
  end

  stack_depth_cnt #(
    .DEPTH (DEPTH),
    .W     (DW),
    .WRAP  (WRAP)
  ) u_depth (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .inc   (push),
    .dec   (pop),
    .depth (depth_o),
    .full  (full),
    .empty (empty)
  );

  assign stk_push_o = push;
  assign stk_pop_o  = pop;
  assign stk_pc_o   = next_pc_i;
  assign pc_o       = pc_q;
  assign ie_o       = ie_q;
  assign flags_o    = flags_q;
  assign err_o      = err_q;
endmodule

// File: tb/tb_stack_seq_ctrl.sv
// Bench for stack_seq_ctrl: directed scenarios plus randomized traffic against a queue-based model.
module tb_stack_seq_ctrl;
  localparam int          DEPTH = 8;
  localparam int          DW    = $clog2(DEPTH + 1);
  localparam logic [11:0] IVEC  = 12'h001;
`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cen, call_i, ret_i, reti_i, int_req_i;
  logic [11:0] next_pc_i, call_tgt_i, stk_top_i;
  logic [1:0]  flags_i;
  logic stk_push_o, stk_pop_o, busy_o, int_ack_o, ie_o, flags_ld_o, err_o;
  logic [11:0] stk_pc_o, pc_o;
  logic [1:0]  flags_o;
  logic [DW-1:0] depth_o;

  stack_seq_ctrl dut (
    .clk(clk), .rst(rst), .cen(cen), .next_pc_i(next_pc_i), .call_i(call_i),
    .call_tgt_i(call_tgt_i), .ret_i(ret_i), .reti_i(reti_i), .int_req_i(int_req_i),
    .flags_i(flags_i), .stk_top_i(stk_top_i), .stk_push_o(stk_push_o), .stk_pop_o(stk_pop_o),
    .stk_pc_o(stk_pc_o), .pc_o(pc_o), .busy_o(busy_o), .int_ack_o(int_ack_o), .ie_o(ie_o),
    .flags_ld_o(flags_ld_o), .flags_o(flags_o), .depth_o(depth_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: program-level view (pending pop kind, trapped, stack as a queue)
  logic [11:0] m_pc;
  int          m_depth;
  bit          m_ie, m_err, m_trap;
  logic [1:0]  m_flags;
  int          m_pend;          // 0 none, 1 ret result due, 2 reti result due
  logic [11:0] m_stk[$];

  // strobes observed in the last cycle
  logic s_push, s_pop, s_ack, s_fld, s_busy;
  logic [11:0] s_stkpc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic r, input logic ce, input logic c, input logic [11:0] tgt,
                     input logic rt, input logic rti, input logic q, input logic [1:0] fl,
                     input logic [11:0] npc);
    rst = r; cen = ce; call_i = c; call_tgt_i = tgt; ret_i = rt; reti_i = rti;
    int_req_i = q; flags_i = fl; next_pc_i = npc;
  endtask

  task automatic mpush(input logic [11:0] v);
    if (m_stk.size() == DEPTH) void'(m_stk.pop_front());
    m_stk.push_back(v);
  endtask

  task automatic tick();
    bit e_push, e_pop, e_ack, e_fld, e_busy, popped, fault;
    logic [11:0] pv, n_pc;
    int n_depth, n_pend;
    bit n_ie, n_err, n_trap;
    logic [1:0] n_flags;
    e_push = 0; e_pop = 0; e_ack = 0; e_fld = 0; popped = 0; fault = 0; pv = '0;
    e_busy  = m_trap || (m_pend != 0);
    n_pc = m_pc; n_depth = m_depth; n_pend = m_pend; n_ie = m_ie; n_err = m_err;
    n_trap = m_trap; n_flags = m_flags;
    if (rst) begin
      n_pc = 12'h000; n_depth = 0; n_pend = 0; n_ie = 1; n_err = 0; n_trap = 0; n_flags = 0;
      m_stk.delete();
    end else if (cen && !m_trap) begin
      if (m_pend != 0) begin
        n_pc = stk_top_i; n_pend = 0;
        if (m_pend == 2) begin e_fld = 1; n_ie = 1; end
      end else if (call_i || (!ret_i && !reti_i && int_req_i && m_ie)) begin
        if (GUARD && m_depth == DEPTH) fault = 1;
        else begin
          e_push = 1; mpush(next_pc_i);
          n_depth = (m_depth + 1) % (DEPTH + 1);
          if (call_i) n_pc = call_tgt_i;
          else begin n_pc = IVEC; e_ack = 1; n_ie = 0; n_flags = flags_i; end
        end
      end else if (ret_i || reti_i) begin
        if (GUARD && m_depth == 0) fault = 1;
        else begin
          e_pop = 1; popped = 1;
          pv = (m_stk.size() > 0) ? m_stk.pop_back() : 12'h000;
          n_depth = (m_depth + DEPTH) % (DEPTH + 1);
          n_pend = ret_i ? 1 : 2;
        end
      end else begin
        n_pc = next_pc_i;
      end
      if (fault) begin n_trap = 1; n_err = 1; n_pc = IVEC; end
    end
    @(negedge clk);
    s_push = stk_push_o; s_pop = stk_pop_o; s_ack = int_ack_o; s_fld = flags_ld_o;
    s_busy = busy_o; s_stkpc = stk_pc_o;
    chk("push", 16'(stk_push_o), 16'(e_push));
    chk("pop", 16'(stk_pop_o), 16'(e_pop));
    chk("int_ack", 16'(int_ack_o), 16'(e_ack));
    chk("flags_ld", 16'(flags_ld_o), 16'(e_fld));
    chk("busy", 16'(busy_o), 16'(e_busy));
    if (e_push) chk("stk_pc", 16'(stk_pc_o), 16'(next_pc_i));
    @(posedge clk);
    #1;
    m_pc = n_pc; m_depth = n_depth; m_pend = n_pend; m_ie = n_ie; m_err = n_err;
    m_trap = n_trap; m_flags = n_flags;
    if (popped) stk_top_i = pv;
    chk("pc", 16'(pc_o), 16'(m_pc));
    chk("depth", 16'(depth_o), 16'(m_depth));
    chk("ie", 16'(ie_o), 16'(m_ie));
    chk("flags", 16'(flags_o), 16'(m_flags));
    chk("err", 16'(err_o), 16'(m_err));
  endtask

  task automatic idle(input logic [11:0] npc);
    drv(0, 1, 0, 12'h0, 0, 0, 0, 2'b00, npc);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    stk_top_i = 12'h000;
    m_pc = 0; m_depth = 0; m_ie = 1; m_err = 0; m_trap = 0; m_flags = 0; m_pend = 0;
    // 1: reset and idle sequencing
    drv(1, 1, 0, 12'h0, 0, 0, 0, 2'b00, 12'h0);
    tick();
    chk("rst_pc", 16'(pc_o), 16'h000);
    chk("rst_depth", 16'(depth_o), 16'h0);
    chk("rst_ie", 16'(ie_o), 16'h1);
    chk("rst_err", 16'(err_o), 16'h0);
    for (int i = 1; i <= 3; i++) begin
      idle(12'(i));
      chk("idle_pc", 16'(pc_o), 16'(i));
      chk("idle_push", 16'(s_push), 16'h0);
    end
    // 2: call then ret
    drv(0, 1, 1, 12'h100, 0, 0, 0, 2'b00, 12'h011);
    tick();
    chk("t2_push", 16'(s_push), 16'h1);
    chk("t2_stkpc", 16'(s_stkpc), 16'h011);
    chk("t2_pc", 16'(pc_o), 16'h100);
    chk("t2_depth", 16'(depth_o), 16'h1);
    drv(0, 1, 0, 12'h0, 1, 0, 0, 2'b00, 12'h101);
    tick();
    chk("t2_pop", 16'(s_pop), 16'h1);
    idle(12'h101);
    chk("t2_busy", 16'(s_busy), 16'h1);
    chk("t2_retpc", 16'(pc_o), 16'h011);
    chk("t2_depth0", 16'(depth_o), 16'h0);
    // 3: interrupt entry and reti
    drv(0, 1, 0, 12'h0, 0, 0, 1, 2'b10, 12'h020);
    tick();
    chk("t3_ack", 16'(s_ack), 16'h1);
    chk("t3_pc", 16'(pc_o), 16'h001);
    chk("t3_ie", 16'(ie_o), 16'h0);
    drv(0, 1, 0, 12'h0, 0, 1, 0, 2'b00, 12'h002);
    tick();
    idle(12'h002);
    chk("t3_fld", 16'(s_fld), 16'h1);
    chk("t3_flags", 16'(flags_o), 16'h2);
    chk("t3_ie1", 16'(ie_o), 16'h1);
    chk("t3_pc2", 16'(pc_o), 16'h020);
    // 4: call beats interrupt; interrupt retaken next cycle
    drv(0, 1, 1, 12'h200, 0, 0, 1, 2'b01, 12'h030);
    tick();
    chk("t4_push", 16'(s_push), 16'h1);
    chk("t4_noack", 16'(s_ack), 16'h0);
    chk("t4_pc", 16'(pc_o), 16'h200);
    drv(0, 1, 0, 12'h0, 0, 0, 1, 2'b01, 12'h201);
    tick();
    chk("t4_ack", 16'(s_ack), 16'h1);
    chk("t4_stkpc", 16'(s_stkpc), 16'h201);
    chk("t4_pc2", 16'(pc_o), 16'h001);
    chk("t4_depth", 16'(depth_o), 16'h2);
    drv(0, 1, 0, 12'h0, 0, 1, 0, 2'b00, 12'h002);
    tick();
    idle(12'h002);
    chk("t4_reti_pc", 16'(pc_o), 16'h201);
    drv(0, 1, 0, 12'h0, 1, 0, 0, 2'b00, 12'h202);
    tick();
    idle(12'h202);
    chk("t4_ret_pc", 16'(pc_o), 16'h030);
    chk("t4_depth0", 16'(depth_o), 16'h0);
    // 5: nine nested calls
    drv(1, 1, 0, 12'h0, 0, 0, 0, 2'b00, 12'h0);
    tick();
    for (int i = 0; i < 9; i++) begin
      drv(0, 1, 1, 12'(12'h300 + i), 0, 0, 0, 2'b00, 12'(12'h010 + i));
      tick();
    end
    if (GUARD) begin
      chk("t5_nopush", 16'(s_push), 16'h0);
      chk("t5_err", 16'(err_o), 16'h1);
      chk("t5_pc", 16'(pc_o), 16'h001);
      chk("t5_depth", 16'(depth_o), 16'h8);
      idle(12'h055);
      chk("t5_busy", 16'(s_busy), 16'h1);
      chk("t5_pchold", 16'(pc_o), 16'h001);
    end else begin
      chk("t5_push", 16'(s_push), 16'h1);
      chk("t5_err", 16'(err_o), 16'h0);
      chk("t5_depth", 16'(depth_o), 16'h0);
      chk("t5_pc", 16'(pc_o), 16'h308);
    end
    // 6: reset while held in the pop-result cycle with cen low
    drv(1, 1, 0, 12'h0, 0, 0, 0, 2'b00, 12'h0);
    tick();
    drv(0, 1, 1, 12'h050, 0, 0, 0, 2'b00, 12'h005);
    tick();
    drv(0, 1, 0, 12'h0, 0, 1, 0, 2'b00, 12'h051);
    tick();
    drv(0, 0, 0, 12'h0, 0, 0, 0, 2'b00, 12'h051);
    tick();
    chk("t6_busy_hold", 16'(s_busy), 16'h1);
    chk("t6_fld_cen0", 16'(s_fld), 16'h0);
    drv(1, 0, 0, 12'h0, 0, 0, 0, 2'b00, 12'h051);
    tick();
    chk("t6_fld_rst", 16'(s_fld), 16'h0);
    chk("t6_pc", 16'(pc_o), 16'h000);
    chk("t6_depth", 16'(depth_o), 16'h0);
    chk("t6_busy", 16'(busy_o), 16'h0);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      bit c, r, ri, q;
      c  = ($urandom_range(0, 99) < 20) && (m_depth < DEPTH);
      r  = ($urandom_range(0, 99) < 15) && (m_depth > 0);
      ri = ($urandom_range(0, 99) < 10) && (m_depth > 0);
      q  = ($urandom_range(0, 99) < 25) && (m_depth < DEPTH);
      drv(0, $urandom_range(0, 9) != 0, c, 12'($urandom()), r, ri, q,
          2'($urandom()), 12'($urandom()));
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
